// File: rtl/atmega_ppgm_seq_pkg.sv
// Shared definitions for the ATmega parallel-programming sequencer:
// op codes, FSM state encoding, default timing and small decode helpers.
package atmega_ppgm_seq_pkg;

    // Host operation codes
    localparam logic [2:0] OP_LOAD_CMD     = 3'd0;
    localparam logic [2:0] OP_LOAD_ADDR_LO = 3'd1;
    localparam logic [2:0] OP_LOAD_ADDR_HI = 3'd2;
    localparam logic [2:0] OP_LOAD_DATA_LO = 3'd3;
    localparam logic [2:0] OP_LOAD_DATA_HI = 3'd4;
    localparam logic [2:0] OP_LATCH_PAGE   = 3'd5;
    localparam logic [2:0] OP_WRITE        = 3'd6;
    localparam logic [2:0] OP_READ         = 3'd7;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_HOLD      = 3'd3,
        ST_GUARD     = 3'd4,
        ST_RDY_WAIT  = 3'd5,
        ST_RD_SETUP  = 3'd6,
        ST_RD_SAMPLE = 3'd7
    } ppgm_state_e;

    // Default timing, in clk cycles
    localparam int          DEF_PULSE_CYC   = 4;
    localparam int          DEF_SETUP_CYC   = 2;
    localparam int          DEF_GUARD_CYC   = 8;
    localparam logic [15:0] DEF_TIMEOUT_CYC = 16'hFFFF;

    // A state lasting cyc cycles loads cyc-1 and leaves when the count is 0.
    function automatic logic [15:0] cyc_to_load(input logic [15:0] cyc);
        return (cyc == 16'd0) ? 16'd0 : (cyc - 16'd1);
    endfunction

    // {XA1, XA0, BS1} pin pattern for the LOAD ops.
    function automatic logic [2:0] load_sel(input logic [2:0] op);
        logic [2:0] sel;
        case (op)
            OP_LOAD_CMD:     sel = 3'b100;
            OP_LOAD_ADDR_LO: sel = 3'b000;
            OP_LOAD_ADDR_HI: sel = 3'b001;
            OP_LOAD_DATA_LO: sel = 3'b010;
            OP_LOAD_DATA_HI: sel = 3'b011;
            default:         sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/atmega_ppgm_seq_timer.sv
// Shared 16-bit down-counter for every timed sequencer state.
module ppgm_cycle_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic [15:0] o_value,
    output logic        o_zero
);

    logic [15:0] r_cnt;

    // Reload on state entry, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == 16'd0);

endmodule

// File: rtl/atmega_ppgm_seq.sv
// ATmega high-voltage parallel-programming pin sequencer: turns host ops
// into XTAL/PAGEL/WR/OE strobes with setup, hold, guard and RDY handling.
module atmega_ppgm_seq
    import atmega_ppgm_seq_pkg::*;
#(
    parameter int          PULSE_CYC   = DEF_PULSE_CYC,
    parameter int          SETUP_CYC   = DEF_SETUP_CYC,
    parameter int          GUARD_CYC   = DEF_GUARD_CYC,
    parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_arg,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       timeout,
    output logic       dut_xa1,
    output logic       dut_xa0,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_wr_n,
    output logic       dut_oe_n,
    output logic [7:0] dut_dout,
    output logic       dut_doe,
    input  logic [7:0] dut_din,
    input  logic       dut_rdy
);

    localparam logic [15:0] LD_PULSE   = cyc_to_load(16'(PULSE_CYC));
    localparam logic [15:0] LD_SETUP   = cyc_to_load(16'(SETUP_CYC));
    localparam logic [15:0] LD_GUARD   = cyc_to_load(16'(GUARD_CYC));
    localparam logic [15:0] LD_TIMEOUT = cyc_to_load(TIMEOUT_CYC);

    ppgm_state_e r_state;
    logic [2:0]  r_op;
    logic        r_done;
    logic        r_timeout;
    logic [7:0]  r_rd_data;
    logic        r_xa1, r_xa0, r_bs1, r_bs2;
    logic        r_xtal, r_pagel, r_wr_n, r_oe_n;
    logic [7:0]  r_dout;
    logic        r_doe;

    logic        w_tmr_load;
    logic [15:0] w_tmr_val;
    logic [15:0] w_tmr_value;
    logic        w_tmr_zero;
    logic        w_tmr_expired;

    ppgm_cycle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_value    (w_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    // Zero flag is cross-checked against the count so a flag fault cannot end a state early.
    assign w_tmr_expired = w_tmr_zero & ~(|w_tmr_value);

    // Reload the timer with the duration of whichever timed state is entered next.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = 16'd0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = LD_SETUP;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            ST_SETUP: begin
                if (w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = LD_PULSE;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            ST_PULSE: begin
                if (w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = (r_op == OP_WRITE) ? LD_GUARD : LD_SETUP;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            ST_GUARD: begin
                if (w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = LD_TIMEOUT;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            ST_RD_SETUP: begin
                if (w_tmr_expired) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = 16'd0;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with all pin and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD_CMD;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rd_data <= 8'h00;
            r_xa1     <= 1'b0;
            r_xa0     <= 1'b0;
            r_bs1     <= 1'b0;
            r_bs2     <= 1'b0;
            r_xtal    <= 1'b0;
            r_pagel   <= 1'b0;
            r_wr_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_dout    <= 8'h00;
            r_doe     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_op      <= op_code;
                        r_timeout <= 1'b0;
                        case (op_code)
                            OP_LOAD_CMD, OP_LOAD_ADDR_LO, OP_LOAD_ADDR_HI,
                            OP_LOAD_DATA_LO, OP_LOAD_DATA_HI: begin
                                {r_xa1, r_xa0, r_bs1} <= load_sel(op_code);
                                r_dout  <= op_arg;
                                r_doe   <= 1'b1;
                                r_state <= ST_SETUP;
                            end
                            OP_LATCH_PAGE: begin
                                r_bs1   <= 1'b1;
                                r_doe   <= 1'b0;
                                r_state <= ST_SETUP;
                            end
                            OP_WRITE: begin
                                r_bs1   <= op_arg[0];
                                r_bs2   <= op_arg[1];
                                r_doe   <= 1'b0;
                                r_state <= ST_SETUP;
                            end
                            OP_READ: begin
                                r_bs1   <= op_arg[0];
                                r_bs2   <= op_arg[1];
                                r_doe   <= 1'b0;
                                r_oe_n  <= 1'b0;
                                r_state <= ST_RD_SETUP;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_expired) begin
                        case (r_op)
                            OP_LATCH_PAGE: r_pagel <= 1'b1;
                            OP_WRITE:      r_wr_n  <= 1'b0;
                            default:       r_xtal  <= 1'b1;
                        endcase
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_tmr_expired) begin
                        r_xtal  <= 1'b0;
                        r_pagel <= 1'b0;
                        r_wr_n  <= 1'b1;
                        r_state <= (r_op == OP_WRITE) ? ST_GUARD : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_expired) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_GUARD: begin
                    if (w_tmr_expired) begin
                        r_state <= ST_RDY_WAIT;
                    end
                end
                ST_RDY_WAIT: begin
                    if (dut_rdy) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_tmr_expired) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RD_SETUP: begin
                    if (w_tmr_expired) begin
                        r_state <= ST_RD_SAMPLE;
                    end
                end
                ST_RD_SAMPLE: begin
                    r_rd_data <= dut_din;
                    r_oe_n    <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (r_state == ST_IDLE);
    assign done      = r_done;
    assign rd_data   = r_rd_data;
    assign timeout   = r_timeout;
    assign dut_xa1   = r_xa1;
    assign dut_xa0   = r_xa0;
    assign dut_bs1   = r_bs1;
    assign dut_bs2   = r_bs2;
    assign dut_xtal  = r_xtal;
    assign dut_pagel = r_pagel;
    assign dut_wr_n  = r_wr_n;
    assign dut_oe_n  = r_oe_n;
    assign dut_dout  = r_dout;
    assign dut_doe   = r_doe;

endmodule
